sram_req_ctrl: RTL and testbench

//  Request-side controller directly upstream of the simple_single single-port RAM; sole driver of its port.

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_rsp_fifo.sv | 53 +++++
 rtl/sram_req_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_req_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the SRAM request controller.
// The optional RAM zero-fill is selected by the SRAM_CTRL_INIT_EN macro in sram_req_ctrl.
package sram_ctrl_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH = 2;
   localparam int DEF_WE_WIDTH   = DEF_WIDTH / 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [DEF_WE_WIDTH-1:0] be_all();
      return '1;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Show-ahead response FIFO for read data returning from the RAM.
// Head entry is presented combinationally; count feeds the request-side credit check.
module sram_rsp_fifo
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       valid,
   output logic [WIDTH-1:0]           data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop_ok;

   assign pop_ok = pop && (count != '0);

   // Entries are reset so rsp_data reads zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign valid = (count != '0);
   assign data  = mem[rd_ptr];

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for a single-port RAM: issue registers, read credits, response FIFO.
// Define SRAM_CTRL_INIT_EN to zero-fill the RAM after reset before accepting requests.
//
// state | meaning
// INIT  | post-reset; optional zero-fill in progress, requests not accepted
// RUN   | normal operation until reset
module sram_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WE_WIDTH   = DEF_WE_WIDTH,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WE_WIDTH-1:0]   req_be,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  init_done,
   output logic                  ram_en,
   output logic [WE_WIDTH-1:0]   ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0]      ram_din,
   input  logic [WIDTH-1:0]      ram_dout
);

   localparam int CW = $clog2(RSP_DEPTH) + 1;

   state_t                state;
   state_t                state_nxt;
   logic                  accept;
   logic                  rd_issue;
   logic                  rd_capture;
   logic [CW-1:0]         fifo_count;
   logic [CW-1:0]         credits;
   logic                  init_wr;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  fill_done;

`ifdef SRAM_CTRL_INIT_EN
   logic [ADDR_WIDTH:0] fill_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           fill_cnt <= '0;
      else if (init_wr)  fill_cnt <= fill_cnt + (ADDR_WIDTH+1)'(1);
   end

   assign init_wr   = (state == INIT) && !fill_cnt[ADDR_WIDTH];
   assign init_addr = fill_cnt[ADDR_WIDTH-1:0];
   assign fill_done = fill_cnt[ADDR_WIDTH];
`else
   assign init_wr   = 1'b0;
   assign init_addr = '0;
   assign fill_done = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == INIT && fill_done) state_nxt = RUN;
   end

   // Reads occupy a credit from accept until popped, including the two RAM pipeline stages.
   assign credits = fifo_count + CW'(rd_issue) + CW'(rd_capture);

   always_comb begin
      req_ready = (state == RUN) && (credits < CW'(RSP_DEPTH));
      init_done = (state == RUN);
   end

   assign accept = req_valid && req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_en     <= 1'b0;
         ram_we     <= '0;
         ram_addr   <= '0;
         ram_din    <= '0;
         rd_issue   <= 1'b0;
         rd_capture <= 1'b0;
      end else begin
         rd_capture <= rd_issue;
         if (init_wr) begin
            ram_en   <= 1'b1;
            ram_we   <= be_all();
            ram_addr <= init_addr;
            ram_din  <= '0;
            rd_issue <= 1'b0;
         end else if (accept) begin
            ram_en   <= req_wr;
            ram_we   <= req_wr ? req_be : '0;
            ram_addr <= req_addr;
            if (req_wr) ram_din <= req_wdata;
            rd_issue <= !req_wr;
         end else begin
            ram_en   <= 1'b0;
            ram_we   <= '0;
            rd_issue <= 1'b0;
         end
      end
   end

   sram_rsp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_capture),
      .push_data (ram_dout),
      .pop       (rsp_ready),
      .valid     (rsp_valid),
      .data      (rsp_data),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural single-port RAM attached.
// Follows SRAM_CTRL_INIT_EN so the init sequence checks match the build.
module tb_sram_req_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [1:0]  req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        init_done;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [1:0]  ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef SRAM_CTRL_INIT_EN
   localparam logic [31:0] PRESET = 32'ha5a5a5a5;
`else
   localparam logic [31:0] PRESET = 32'h0;
`endif

   sram_req_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .init_done (init_done),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: write when ram_en, otherwise registered read of ram_addr.
   logic [31:0] mem [4];
   logic        mem_preset;

   always @(posedge clk) begin
      if (mem_preset) begin
         for (int i = 0; i < 4; i++) mem[i] <= PRESET;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the caller 1 time unit after the accepting edge.
   task automatic issue(input logic wr, input logic [1:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
      bit ok = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] exp);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
      check(tag, rsp_data, exp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // Read with exact latency check; assumes the FIFO is empty beforehand.
   task automatic read_lat(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      issue(1'b0, addr, 4'h0, 32'h0);
      check({tag, "_en"}, {31'd0, ram_en}, 32'd0);
      check({tag, "_v0"}, {31'd0, rsp_valid}, 32'd0);
      tick();
      check({tag, "_v1"}, {31'd0, rsp_valid}, 32'd0);
      tick();
      check({tag, "_v2"}, {31'd0, rsp_valid}, 32'd1);
      pop_expect(tag, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_en"},   {31'd0, ram_en},    32'd0);
      check({tag, "_we"},   {28'd0, ram_we},    32'd0);
      check({tag, "_addr"}, {30'd0, ram_addr},  32'd0);
      check({tag, "_din"},  ram_din,            32'd0);
      check({tag, "_rdy"},  {31'd0, req_ready}, 32'd0);
      check({tag, "_rv"},   {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rd"},   rsp_data,           32'd0);
      check({tag, "_id"},   {31'd0, init_done}, 32'd0);
   endtask

   task automatic wait_init();
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (init_done) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check("init_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      mem_preset = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = 2'd0;
      req_be     = 4'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;
      tick();
      tick();
      mem_preset = 1'b0;
      check_reset_outputs("rst");

      // Test 1: init sequence, then reads of every address return zero.
      req_valid = 1'b1;
      req_wr    = 1'b0;
      rst       = 1'b0;
      check("init_id0", {31'd0, init_done}, 32'd0);
`ifdef SRAM_CTRL_INIT_EN
      for (int k = 0; k < 4; k++) begin
         tick();
         check("fill_en",   {31'd0, ram_en},    32'd1);
         check("fill_we",   {28'd0, ram_we},    32'hf);
         check("fill_addr", {30'd0, ram_addr},  k);
         check("fill_din",  ram_din,            32'd0);
         check("fill_rdy",  {31'd0, req_ready}, 32'd0);
         check("fill_id",   {31'd0, init_done}, 32'd0);
      end
`endif
      tick();
      check("init_id1", {31'd0, init_done}, 32'd1);
      check("init_en",  {31'd0, ram_en},    32'd0);
      check("init_rdy", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      tick();
      for (int a = 0; a < 4; a++) read_lat("init_rd", 2'(a), 32'h0);

      // Test 2: full-word writes then reads.
      issue(1'b1, 2'd0, 4'hf, 32'h01234567);
      check("wr_en",   {31'd0, ram_en},   32'd1);
      check("wr_we",   {28'd0, ram_we},   32'hf);
      check("wr_addr", {30'd0, ram_addr}, 32'd0);
      check("wr_din",  ram_din,           32'h01234567);
      issue(1'b1, 2'd1, 4'hf, 32'h89abcdef);
      tick();
      check("idle_en",  {31'd0, ram_en},   32'd0);
      check("idle_din", ram_din,           32'h89abcdef);
      read_lat("rd0", 2'd0, 32'h01234567);
      read_lat("rd1", 2'd1, 32'h89abcdef);

      // Test 3: partial byte-lane write.
      issue(1'b1, 2'd0, 4'h3, 32'h10111213);
      read_lat("be", 2'd0, 32'h01231213);

      // rsp_ready with an empty FIFO must not disturb credits.
      rsp_ready = 1'b1;
      tick();
      tick();
      rsp_ready = 1'b0;
      check("empty_pop_rv",  {31'd0, rsp_valid}, 32'd0);
      check("empty_pop_rdy", {31'd0, req_ready}, 32'd1);

      // Test 4: credit backpressure with three back-to-back reads.
      issue(1'b1, 2'd2, 4'hf, 32'h5555aaaa);
      tick();
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 2'd0;
      check("bp_rdy0", {31'd0, req_ready}, 32'd1);
      tick();
      req_addr = 2'd1;
      check("bp_rdy1", {31'd0, req_ready}, 32'd1);
      tick();
      req_addr = 2'd2;
      check("bp_full", {31'd0, req_ready}, 32'd0);
      tick();
      tick();
      tick();
      check("bp_hold",  {31'd0, req_ready}, 32'd0);
      check("bp_rv",    {31'd0, rsp_valid}, 32'd1);
      check("bp_head",  rsp_data,           32'h01231213);
      tick();
      check("bp_stable", rsp_data,          32'h01231213);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_reopen", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      pop_expect("bp_r1", 32'h89abcdef);
      pop_expect("bp_r2", 32'h5555aaaa);
      tick();
      tick();
      check("bp_drained", {31'd0, rsp_valid}, 32'd0);

      // Test 5: read immediately after write to the same address.
      issue(1'b1, 2'd2, 4'hf, 32'hdeadbeef);
      issue(1'b0, 2'd2, 4'h0, 32'h0);
      pop_expect("raw", 32'hdeadbeef);

      // Test 6: reset with two reads in flight.
      issue(1'b0, 2'd0, 4'h0, 32'h0);
      issue(1'b0, 2'd1, 4'h0, 32'h0);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      tick();
      check_reset_outputs("mid_rst_hold");
      rst = 1'b0;
      wait_init();
      for (int i = 0; i < 5; i++) tick();
      check("post_rst_rv", {31'd0, rsp_valid}, 32'd0);
      check("post_rst_rdy", {31'd0, req_ready}, 32'd1);
`ifdef SRAM_CTRL_INIT_EN
      read_lat("post_rst_rd", 2'd2, 32'h0);
`else
      read_lat("post_rst_rd", 2'd2, 32'hdeadbeef);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
